// File: rtl/regfile_pkg.sv
// Shared definitions for the int/FP register file with a pending-write scoreboard.
// A write request bundles everything one write port presents in a cycle.
// The request struct is sized for the default configuration (RF_XLEN, RF_NREG).
// Instances using wider data or more registers need a wider struct.
package regfile_pkg;

  localparam int RF_XLEN = 32;
  localparam int RF_NREG = 32;

  function automatic int rf_aw(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  localparam int RF_AW = rf_aw(RF_NREG);

  typedef struct packed {
    logic               en;
    logic               fp;
    logic               dbl;
    logic [RF_AW-1:0]   addr;
    logic [RF_XLEN-1:0] lo;
    logic [RF_XLEN-1:0] hi;
  } wr_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for the long-latency FP unit.
// It tracks the per-register busy bits, the outstanding-operation count, issue
// acceptance and the sticky protocol-error flag.
// Optional macro REGFILE_BYPASS_EN: busy bits being cleared by this cycle's
// writeback are reported as already clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREG     = RF_NREG,
  parameter  int MAX_PEND = 4,
  localparam int AW       = rf_aw(NREG),
  localparam int CW       = $clog2(MAX_PEND + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_en,
  input  logic            iss_dbl,
  input  logic [AW-1:0]   iss_addr,
  input  logic            wb_en,
  input  logic            wb_dbl,
  input  logic [AW-1:0]   wb_addr,
  input  logic            collide,
  output logic            iss_ok,
  output logic [NREG-1:0] busy_rd,
  output logic [CW-1:0]   pend_cnt,
  output logic            pend_full,
  output logic            err
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] iss_mask;
  logic [NREG-1:0] wb_clr;
  logic [NREG-1:0] busy_d;
  logic [CW-1:0]   cnt_d;
  logic            underflow;

  // A register and, for a double, its wrapped partner.
  function automatic logic [NREG-1:0] pair_mask(input logic [AW-1:0] a, input logic dbl);
    logic [NREG-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    if (dbl) m[a + AW'(1)] = 1'b1;
    return m;
  endfunction

  assign pend_full = (pend_cnt == CW'(MAX_PEND));
  assign underflow = wb_en & (pend_cnt == '0);

  // Issue acceptance and next busy/count values; an issue set beats a writeback clear.
  always_comb begin
    iss_mask = pair_mask(iss_addr, iss_dbl);
    wb_clr   = wb_en ? pair_mask(wb_addr, wb_dbl) : '0;
    iss_ok   = iss_en & ~pend_full & ~(|(busy_q & iss_mask));
    busy_d   = (busy_q & ~wb_clr) | (iss_ok ? iss_mask : '0);
    cnt_d    = pend_cnt;
    if (iss_ok & ~wb_en) begin
      cnt_d = pend_cnt + CW'(1);
    end else if (~iss_ok & wb_en & (pend_cnt != '0)) begin
      cnt_d = pend_cnt - CW'(1);
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign busy_rd = busy_q & ~wb_clr;
`else
  assign busy_rd = busy_q;
`endif

  // Scoreboard state; err is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      pend_cnt <= '0;
      err      <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      pend_cnt <= cnt_d;
      err      <= err | underflow | collide;
    end
  end

endmodule

// File: rtl/mips_regfile_sb.sv
// Integer/FP register file with NRD combinational read ports.
// Every read port returns a double-precision pair: the low word comes from the
// selected bank, and the high word always comes from FP[(addr+1) mod NREG].
// Port A is the single-cycle ALU/load path. Port B is the FP-unit writeback.
// When both ports write the same FP register, port A wins and err is raised.
// Optional macro REGFILE_BYPASS_EN: reads see same-cycle write data, with
// port A taking priority over port B.
module mips_regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN     = RF_XLEN,
  parameter  int NREG     = RF_NREG,
  parameter  int NRD      = 2,
  parameter  int MAX_PEND = 4,
  localparam int AW       = rf_aw(NREG),
  localparam int CW       = $clog2(MAX_PEND + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD-1:0]      rd_fp,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_lo,
  output logic [NRD*XLEN-1:0] rd_hi,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wa_en,
  input  logic                wa_fp,
  input  logic                wa_dbl,
  input  logic [AW-1:0]       wa_addr,
  input  logic [XLEN-1:0]     wa_lo,
  input  logic [XLEN-1:0]     wa_hi,
  input  logic                iss_en,
  input  logic                iss_dbl,
  input  logic [AW-1:0]       iss_addr,
  output logic                iss_ok,
  input  logic                wb_en,
  input  logic                wb_dbl,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_lo,
  input  logic [XLEN-1:0]     wb_hi,
  output logic [CW-1:0]       pend_cnt,
  output logic                pend_full,
  output logic                err
);

  wr_req_t         wa_req;
  wr_req_t         wb_req;
  logic [XLEN-1:0] int_q  [NREG];
  logic [XLEN-1:0] fp_q   [NREG];
  logic [XLEN-1:0] int_wd [NREG];
  logic [XLEN-1:0] fp_wd  [NREG];
  logic [NREG-1:0] fp_col;
  logic [NREG-1:0] busy_rd;
  logic [1:0]      ha;
  logic [1:0]      hb;
  logic [AW-1:0]   ra;
  logic [AW-1:0]   rb;

  assign wa_req = '{en: wa_en, fp: wa_fp, dbl: wa_dbl, addr: RF_AW'(wa_addr),
                    lo: RF_XLEN'(wa_lo), hi: RF_XLEN'(wa_hi)};
  // Port B always targets the FP bank.
  assign wb_req = '{en: wb_en, fp: 1'b1, dbl: wb_dbl, addr: RF_AW'(wb_addr),
                    lo: RF_XLEN'(wb_lo), hi: RF_XLEN'(wb_hi)};

  // Bit 0: the request writes the low word into idx. Bit 1: it writes the pair word into idx.
  function automatic logic [1:0] hit(input wr_req_t r, input logic [AW-1:0] idx);
    logic [AW-1:0] a;
    a      = AW'(r.addr);
    hit[0] = r.en & r.fp & (a == idx);
    hit[1] = r.en & r.fp & r.dbl & ((a + AW'(1)) == idx);
  endfunction

  // Next FP contents per register; port A overrides port B on a collision.
  always_comb begin
    ha     = '0;
    hb     = '0;
    fp_col = '0;
    for (int i = 0; i < NREG; i++) begin
      ha        = hit(wa_req, AW'(i));
      hb        = hit(wb_req, AW'(i));
      fp_col[i] = (|ha) & (|hb);
      if (ha[0])      fp_wd[i] = XLEN'(wa_req.lo);
      else if (ha[1]) fp_wd[i] = XLEN'(wa_req.hi);
      else if (hb[0]) fp_wd[i] = XLEN'(wb_req.lo);
      else if (hb[1]) fp_wd[i] = XLEN'(wb_req.hi);
      else            fp_wd[i] = fp_q[i];
    end
  end

  // Next int contents; r0 is hardwired to zero, so writes to it are dropped.
  always_comb begin
    int_wd[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      if (wa_req.en & ~wa_req.fp & (AW'(wa_req.addr) == AW'(i))) int_wd[i] = XLEN'(wa_req.lo);
      else                                                       int_wd[i] = int_q[i];
    end
  end

  // Register banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        int_q[i] <= '0;
        fp_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        int_q[i] <= int_wd[i];
        fp_q[i]  <= fp_wd[i];
      end
    end
  end

  // Read ports; rb wraps modulo NREG because NREG is a power of two.
  always_comb begin
    ra      = '0;
    rb      = '0;
    rd_lo   = '0;
    rd_hi   = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      ra = rd_addr[p*AW +: AW];
      rb = ra + AW'(1);
`ifdef REGFILE_BYPASS_EN
      rd_lo[p*XLEN +: XLEN] = rd_fp[p] ? fp_wd[ra] : int_wd[ra];
      rd_hi[p*XLEN +: XLEN] = fp_wd[rb];
`else
      rd_lo[p*XLEN +: XLEN] = rd_fp[p] ? fp_q[ra] : int_q[ra];
      rd_hi[p*XLEN +: XLEN] = fp_q[rb];
`endif
      rd_busy[p] = rd_fp[p] & (busy_rd[ra] | busy_rd[rb]);
    end
  end

  regfile_scoreboard #(
    .NREG     (NREG),
    .MAX_PEND (MAX_PEND)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_en    (iss_en),
    .iss_dbl   (iss_dbl),
    .iss_addr  (iss_addr),
    .wb_en     (wb_en),
    .wb_dbl    (wb_dbl),
    .wb_addr   (wb_addr),
    .collide   (|fp_col),
    .iss_ok    (iss_ok),
    .busy_rd   (busy_rd),
    .pend_cnt  (pend_cnt),
    .pend_full (pend_full),
    .err       (err)
  );

endmodule

// File: doc/mips_regfile_sb.md
Name: mips_regfile_sb

Overview:
- Parametrised integer/FP register file with a pending-write scoreboard for the multi-cycle FP unit. Successor to the single-port int/fp register bank.
- Provides NRD combinational read ports, each able to fetch a double-precision pair.
- Has two write ports: port A for the single-cycle ALU/load path, port B for the long-latency FP unit.
- Tracks per-FP-register busy bits and an outstanding-operation counter; decode uses these for stall decisions.

Parameters:
- XLEN, 32, data width of one register.
- NREG, 32, registers per bank (power of 2); AW = clog2(NREG) is a localparam.
- NRD, 2, number of read ports.
- MAX_PEND, 4, max outstanding port-B operations.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- rd_fp  in  NRD  per-port bank select: 1 = FP bank, 0 = int bank.
- rd_addr  in  NRD*AW  per-port register index.
- rd_lo  out  NRD*XLEN  reg[addr].
- rd_hi  out  NRD*XLEN  FP reg[(addr+1) mod NREG]; always from the FP bank.
- rd_busy  out  NRD  busy[addr] | busy[addr+1] for FP reads; 0 for int reads.
- wa_en, wa_fp, wa_dbl  in  1 each  port-A write enable, bank select, double-pair write.
- wa_addr  in  AW  port-A write index.
- wa_lo, wa_hi  in  XLEN each  port-A write data (low / high word).
- iss_en, iss_dbl  in  1 each  issue a long op; marks destination busy.
- iss_addr  in  AW  destination FP register of the issued op.
- iss_ok  out  1  issue accepted (combinational).
- wb_en, wb_dbl  in  1 each  port-B writeback; always FP bank.
- wb_addr  in  AW  port-B write index.
- wb_lo, wb_hi  in  XLEN each  port-B write data.
- pend_cnt  out  clog2(MAX_PEND+1)  outstanding port-B operations.
- pend_full  out  1  pend_cnt == MAX_PEND.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst_n=0): all int/FP registers, busy bits, pend_cnt and err go to 0 immediately. Resetting mid-operation discards all pending state; outputs show zeros while rst_n is low.
- Int register 0 reads 0 always; writes to it are dropped.
- Reads are combinational. Write latency is 1 cycle: data is visible on the first edge after the write.
- Double pair = addr and (addr+1) mod NREG. Index NREG-1 wraps to 0; this is legal, not an error.
- Writes:
  - Port A with wa_fp=0 writes the int bank, low word only.
  - Port A with wa_fp=1 writes FP[addr], plus FP[addr+1] when wa_dbl=1.
  - Port B writes FP[addr] (plus pair when wb_dbl=1) and clears the corresponding busy bit(s).
  - Same FP register written by A and B in the same cycle: port A data wins, err is set.
- Issue:
  - iss_ok = iss_en & !pend_full & no busy bit set on the target register(s).
  - When accepted, target busy bit(s) set at the next edge.
  - Refused issue changes no state. It is not an error; the caller stalls.
  - Same-cycle wb clearing and iss setting the same bit: set wins, register stays busy.
- pend_cnt:
  - +1 on accepted issue, -1 on wb_en, unchanged when both occur.
  - wb_en with pend_cnt==0: data is still written, count stays 0, err is set.
- Port A writing a busy FP register is allowed (WAW by software); busy bit unchanged.
- err is cleared only by reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read whose bank/index matches a same-cycle write returns the write data combinationally. Port A takes priority over port B. Applies per word, including the pair high word. rd_busy for a register being cleared by wb that cycle reads 0.
- Undefined: reads return the pre-edge contents; rd_busy shows the registered busy bits.

Decomposition:
- Package regfile_pkg: XLEN/NREG defaults, AW function, and the typedef wr_req_t {en, fp, dbl, addr, lo, hi} shared by ports A and B.
- One natural sub-module: regfile_scoreboard. It holds the busy vector, pend_cnt, iss_ok, pend_full and the err logic.

Test Plan:
- Reset: write int r5=0x1234, then pulse rst_n low mid-cycle -> r5, pend_cnt, err read 0 immediately, without waiting for a clock edge.
- Int r0: port A writes int r0=0xFFFF_FFFF -> read r0 = 0. Write r7=0xA5A5_A5A5 -> visible on the following cycle.
- Double wrap: port A double write FP31=0x1111_1111 / hi=0x2222_2222 -> rd_lo(31)=0x1111_1111, rd_hi(31)=FP0=0x2222_2222.
- Scoreboard flow: issue to FP4 (dbl) -> rd_busy for addr 4 and addr 5 = 1. A second issue to FP5 -> iss_ok=0. wb to FP4 -> busy clears next cycle, pend_cnt 1->0.
- Full/underflow: 4 accepted issues -> pend_full=1 and a 5th issue is refused. wb_en with pend_cnt=0 -> err=1 and stays 1.
- Port collision: A and B both write FP8 in the same cycle -> FP8 = port A data, err=1. With REGFILE_BYPASS_EN, a same-cycle read of FP8 returns port A data.
